// File: rtl/mul_node_driver.sv
// mul_node_driver: folds a product node's child stream through a fixed-latency FP32 multiplier.
module mul_node_driver #(
    parameter int MUL_LAT = 3,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   child_data,
    input  logic          child_valid,
    input  logic          child_last,
    output logic          child_ready,
    output logic [63:0]   mul_operands,
    output logic          mul_stb,
    input  logic [31:0]   mul_z,
    output logic [31:0]   out_data,
    output logic [CW-1:0] out_count,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int WW = $clog2(MUL_LAT + 1);
    typedef enum logic [2:0] {IDLE, NEXT, ISSUE, WAIT, OUT} state_t;
    state_t        r_state;
    logic [31:0]   r_acc;
    logic          r_last;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wcnt;
    logic [63:0]   r_ops;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_wcnt  <= '0;
            r_ops   <= '0;
        end else begin
            case (r_state)
                IDLE: if (child_valid) begin
                    r_acc   <= child_data;
                    r_count <= CW'(1);
                    r_state <= child_last ? OUT : NEXT;
                end
                // operands are latched here so they are already registered during ISSUE
                NEXT: if (child_valid) begin
                    r_ops   <= {r_acc, child_data};
                    r_last  <= child_last;
                    if (r_count != '1) r_count <= r_count + 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    r_wcnt  <= WW'(MUL_LAT);
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_wcnt <= r_wcnt - 1'b1;
                    if (r_wcnt == WW'(1)) begin
                        r_acc   <= mul_z;
                        r_state <= r_last ? OUT : NEXT;
                    end
                end
                OUT: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign child_ready  = (r_state == IDLE) || (r_state == NEXT);
    assign mul_stb      = (r_state == ISSUE);
    assign out_valid    = (r_state == OUT);
    assign mul_operands = r_ops;
    assign out_data     = r_acc;
    assign out_count    = r_count;
endmodule
